// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// instruction classes and the datapath control bundle.
package rv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBtype  = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluBranch = 2'b01;
    localparam logic [1:0] AluRtype  = 2'b10;
    localparam logic [1:0] AluItype  = 2'b11;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcImm    = 2'b01;
    localparam logic [1:0] PcRegImm = 2'b10;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StTrap
    } state_e;

    typedef enum logic [3:0] {
        ClsNop, ClsRtype, ClsItype, ClsLoad, ClsStore, ClsBtype,
        ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIllegal
    } op_class_e;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       uncond_jump;
        logic       auipc;
        logic       utype;
    } ctrl_t;

    localparam ctrl_t CtrlDefault = '{
        alu_src: 1'b1, alu_op: AluAdd, pc_src: PcPlus4,
        uncond_jump: 1'b0, auipc: 1'b0, utype: 1'b0
    };

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller uses the master
// modport; the datapath side uses slave.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       uncond_jump;
    logic       auipc;
    logic       utype;
    logic       retire;
    logic       fault;

    modport master (
        input  opcode, branch_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, ir_we, pc_we, reg_we, alu_src, alu_op, pc_src,
               mem_wr, mem_to_reg, uncond_jump, auipc, utype, retire, fault
    );

    modport slave (
        output opcode, branch_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ir_we, pc_we, reg_we, alu_src, alu_op, pc_src,
               mem_wr, mem_to_reg, uncond_jump, auipc, utype, retire, fault
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode: raw opcode -> instruction class, and latched class ->
// datapath controls held from EXEC through WB.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  op_class_e  cls,
    output op_class_e  dec_cls,
    output ctrl_t      ctrl
);

    always_comb begin
        dec_cls = ClsIllegal;
        case (opcode)
            OpLoad:  dec_cls = ClsLoad;
            OpStore: dec_cls = ClsStore;
            OpBtype: dec_cls = ClsBtype;
            OpJal:   dec_cls = ClsJal;
            OpJalr:  dec_cls = ClsJalr;
            OpRtype: dec_cls = ClsRtype;
            OpItype: dec_cls = ClsItype;
            OpLui:   dec_cls = ClsLui;
            OpAuipc: dec_cls = ClsAuipc;
            default: dec_cls = ClsIllegal;
        endcase
    end

    always_comb begin
        ctrl = CtrlDefault;
        case (cls)
            ClsBtype: begin
                ctrl.alu_src = 1'b0;
                ctrl.alu_op  = AluBranch;
            end
            ClsRtype: begin
                ctrl.alu_src = 1'b0;
                ctrl.alu_op  = AluRtype;
            end
            ClsItype: ctrl.alu_op = AluItype;
            ClsJal: begin
                ctrl.pc_src      = PcImm;
                ctrl.uncond_jump = 1'b1;
            end
            ClsJalr: begin
                ctrl.pc_src      = PcRegImm;
                ctrl.uncond_jump = 1'b1;
            end
            ClsLui:   ctrl.utype = 1'b1;
            ClsAuipc: begin
                ctrl.auipc = 1'b1;
                ctrl.utype = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a shared
// memory-ack wait counter that faults the core on timeout.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned ILLEGAL_TRAP = 1
) (
    input logic                 clk,
    input logic                 n_rst,
    multicycle_control_if.master bus
);

    localparam int unsigned      CntW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    op_class_e       cls_q, cls_d, dec_cls;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           ctrl;

    ctrl_decode u_decode (
        .opcode  (bus.opcode),
        .cls     (cls_q),
        .dec_cls (dec_cls),
        .ctrl    (ctrl)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StFetch;
            cls_q   <= ClsNop;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cls_d           = cls_q;
        cnt_d           = cnt_q;
        bus.imem_req    = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.ir_we       = 1'b0;
        bus.pc_we       = 1'b0;
        bus.reg_we      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.retire      = 1'b0;
        bus.alu_src     = CtrlDefault.alu_src;
        bus.alu_op      = CtrlDefault.alu_op;
        bus.pc_src      = CtrlDefault.pc_src;
        bus.uncond_jump = CtrlDefault.uncond_jump;
        bus.auipc       = CtrlDefault.auipc;
        bus.utype       = CtrlDefault.utype;

        if (state_q inside {StExec, StMem, StWb}) begin
            bus.alu_src     = ctrl.alu_src;
            bus.alu_op      = ctrl.alu_op;
            bus.pc_src      = ctrl.pc_src;
            bus.uncond_jump = ctrl.uncond_jump;
            bus.auipc       = ctrl.auipc;
            bus.utype       = ctrl.utype;
        end

        case (state_q)
            StFetch: begin
                // Reset is held in FETCH, so the request must be masked while n_rst is low.
                bus.imem_req = n_rst;
                if (bus.imem_ack) begin
                    bus.ir_we = n_rst;
                    state_d   = StDecode;
                end else if (cnt_q == CntLast) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                cls_d = dec_cls;
                if (dec_cls == ClsIllegal) begin
                    if (ILLEGAL_TRAP != 0) begin
                        state_d = StTrap;
                    end else begin
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        state_d    = StFetch;
                    end
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsBtype: begin
                        bus.pc_src = bus.branch_taken ? PcImm : PcPlus4;
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        state_d    = StFetch;
                    end
                    ClsJal, ClsJalr: begin
                        bus.reg_we = 1'b1;
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        state_d    = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                bus.dmem_req = 1'b1;
                bus.mem_wr   = (cls_q == ClsStore);
                if (bus.dmem_ack) begin
                    if (cls_q == ClsStore) begin
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        state_d    = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWb: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = (cls_q == ClsLoad);
                bus.pc_we      = 1'b1;
                bus.pc_src     = PcPlus4;
                bus.retire     = 1'b1;
                state_d        = StFetch;
            end
            StTrap:  ;
            default: state_d = StTrap;
        endcase

        if (state_d != state_q && (state_d == StFetch || state_d == StMem)) begin
            cnt_d = '0;
        end
    end

    assign bus.fault = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control plus directed reset,
// timeout, illegal-opcode and ack-at-limit checks.
module tb_multicycle_control;

    typedef struct packed {
        logic [4:0] lat;
        logic       reg_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       uncond_jump;
        logic       auipc;
        logic       utype;
        logic [4:0] dcyc;
        logic [4:0] wcyc;
    } rec_t;

    logic clk;
    logic n_rst;
    logic n_rst2;
    int   total;
    int   bad;
    rec_t sbq[$];
    logic [6:0] opq[$];

    multicycle_control_if m ();
    multicycle_control_if m2 ();

    multicycle_control dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (m)
    );

    multicycle_control #(
        .MEM_TIMEOUT  (4),
        .ILLEGAL_TRAP (0)
    ) dut2 (
        .clk   (clk),
        .n_rst (n_rst2),
        .bus   (m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: what the retire cycle must look like, and how many cycles after
    // the fetch-ack cycle it arrives, for each instruction kind.
    function automatic rec_t exp_for(input logic [6:0] op, input logic bt, input int d2);
        rec_t r;
        r = '0;
        r.alu_src = 1'b1;
        r.pc_we   = 1'b1;
        case (op)
            7'b0110011: begin r.lat = 5'd3; r.reg_we = 1'b1; r.alu_src = 1'b0; r.alu_op = 2'b10; end
            7'b0010011: begin r.lat = 5'd3; r.reg_we = 1'b1; r.alu_op = 2'b11; end
            7'b0000011: begin
                r.lat = 5'(4 + d2); r.reg_we = 1'b1; r.mem_to_reg = 1'b1; r.dcyc = 5'(d2 + 1);
            end
            7'b0100011: begin
                r.lat = 5'(3 + d2); r.dcyc = 5'(d2 + 1); r.wcyc = 5'(d2 + 1);
            end
            7'b1100011: begin
                r.lat = 5'd2; r.alu_src = 1'b0; r.alu_op = 2'b01; r.pc_src = bt ? 2'b01 : 2'b00;
            end
            7'b1101111: begin r.lat = 5'd2; r.reg_we = 1'b1; r.pc_src = 2'b01; r.uncond_jump = 1'b1; end
            7'b1100111: begin r.lat = 5'd2; r.reg_we = 1'b1; r.pc_src = 2'b10; r.uncond_jump = 1'b1; end
            7'b0110111: begin r.lat = 5'd3; r.reg_we = 1'b1; r.utype = 1'b1; end
            7'b0010111: begin r.lat = 5'd3; r.reg_we = 1'b1; r.auipc = 1'b1; r.utype = 1'b1; end
            default:    r.lat = 5'd1;
        endcase
        return r;
    endfunction

    // Monitor: tracks cycles since the last ir_we and pops one expectation per retire.
    initial begin
        int   since;
        int   dcyc;
        int   wcyc;
        rec_t act;
        rec_t e;
        logic [6:0] op;
        since = 0;
        dcyc  = 0;
        wcyc  = 0;
        forever begin
            @(negedge clk);
            if (m.ir_we) begin
                since = 0;
                dcyc  = 0;
                wcyc  = 0;
            end else begin
                since++;
                if (m.dmem_req) dcyc++;
                if (m.mem_wr) wcyc++;
            end
            if (m.retire) begin
                act.lat         = 5'(since);
                act.reg_we      = m.reg_we;
                act.pc_we       = m.pc_we;
                act.pc_src      = m.pc_src;
                act.mem_to_reg  = m.mem_to_reg;
                act.alu_op      = m.alu_op;
                act.alu_src     = m.alu_src;
                act.uncond_jump = m.uncond_jump;
                act.auipc       = m.auipc;
                act.utype       = m.utype;
                act.dcyc        = 5'(dcyc);
                act.wcyc        = 5'(wcyc);
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL retire_unexpected got=%h want=no_retire", act);
                end else begin
                    e  = sbq.pop_front();
                    op = opq.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL retire_fields op=%b got=%h want=%h", op, act, e);
                    end
                end
            end
        end
    end

    task automatic run_instr(input logic [6:0] op, input int d1, input int d2, input logic bt);
        int n;
        int w;
        n = 0;
        while (!m.imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", 32'(m.imem_req), 32'd1);
        if (!m.imem_req) return;
        for (int i = 0; i < d1; i++) begin
            m.imem_ack = 1'b0;
            m.opcode   = 7'($urandom);
            m.dmem_ack = 1'($urandom);
            tick();
        end
        m.imem_ack     = 1'b1;
        m.opcode       = op;
        m.branch_taken = bt;
        sbq.push_back(exp_for(op, bt, d2));
        opq.push_back(op);
        tick();
        m.imem_ack = 1'($urandom);
        m.dmem_ack = 1'($urandom);
        tick();
        w = 0;
        n = 0;
        while (!m.imem_req && !m.fault && n < 40) begin
            m.opcode   = 7'($urandom);
            m.imem_ack = 1'($urandom);
            if (m.dmem_req) begin
                m.dmem_ack = (w == d2);
                w++;
            end else begin
                m.dmem_ack = 1'($urandom);
            end
            tick();
            n++;
        end
        chk("instr_back_to_fetch", {30'd0, m.imem_req, m.fault}, 32'b10);
    endtask

    initial begin
        logic [6:0] ops [9];
        int n;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        total = 0;
        bad   = 0;
        n_rst = 1'b0;
        n_rst2 = 1'b0;
        m.opcode = '0; m.branch_taken = 1'b0; m.imem_ack = 1'b0; m.dmem_ack = 1'b0;
        m2.opcode = '0; m2.branch_taken = 1'b0; m2.imem_ack = 1'b0; m2.dmem_ack = 1'b0;
        tick();
        tick();
        chk("reset_strobes", {25'd0, m.imem_req, m.dmem_req, m.ir_we, m.retire, m.fault,
                              m.pc_we, m.reg_we}, 32'd0);
        chk("reset_controls", {27'd0, m.alu_src, m.alu_op, m.pc_src}, 32'b10000);

        // ITYPE acked in the first fetch cycle retires in the 4th cycle after release.
        n_rst      = 1'b1;
        m.imem_ack = 1'b1;
        m.opcode   = 7'b0010011;
        sbq.push_back(exp_for(7'b0010011, 1'b0, 0));
        opq.push_back(7'b0010011);
        #1;
        chk("imem_req_after_release", 32'(m.imem_req), 32'd1);
        tick();
        m.imem_ack = 1'b0;
        tick();
        m.opcode = 7'b1111111;
        chk("itype_cycle3_no_retire", 32'(m.retire), 32'd0);
        tick();
        chk("itype_cycle4_retire", {29'd0, m.retire, m.reg_we, m.pc_we}, 32'b111);
        tick();

        for (int k = 0; k < 60; k++) begin
            int d1;
            int d2;
            d1 = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            d2 = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            run_instr(ops[$urandom_range(0, 8)], d1, d2, 1'($urandom));
        end

        // Reset in the middle of a STORE memory access.
        chk("store_fetch_ready", 32'(m.imem_req), 32'd1);
        m.imem_ack = 1'b1;
        m.opcode   = 7'b0100011;
        m.dmem_ack = 1'b0;
        tick();
        m.imem_ack = 1'b0;
        tick();
        tick();
        chk("store_in_mem", {30'd0, m.dmem_req, m.mem_wr}, 32'b11);
        #2;
        n_rst = 1'b0;
        #1;
        chk("reset_drops_dmem", {29'd0, m.dmem_req, m.mem_wr, m.imem_req}, 32'd0);
        tick();
        n_rst = 1'b1;
        #1;
        chk("imem_req_after_store_reset", 32'(m.imem_req), 32'd1);

        // Illegal opcode traps when ILLEGAL_TRAP=1.
        m.imem_ack = 1'b1;
        m.opcode   = 7'b1111111;
        tick();
        m.imem_ack = 1'b0;
        chk("illegal_decode", {30'd0, m.retire, m.fault}, 32'd0);
        tick();
        chk("illegal_trap_fault", 32'(m.fault), 32'd1);
        chk("illegal_trap_quiet", {29'd0, m.imem_req, m.retire, m.pc_we}, 32'd0);

        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        #1;
        chk("reset_clears_fault", {30'd0, m.fault, m.imem_req}, 32'b01);

        // Fetch never acked: fault after exactly MEM_TIMEOUT un-acked cycles, then sticky.
        n = 0;
        while (!m.fault && n < 40) begin
            tick();
            n++;
        end
        chk("fetch_timeout_cycles", 32'(n), 32'd15);
        m.imem_ack = 1'b1;
        m.dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("trap_sticky", {27'd0, m.fault, m.imem_req, m.ir_we, m.retire, m.dmem_req},
                32'b10000);
        end

        // ILLEGAL_TRAP=0, MEM_TIMEOUT=4 instance.
        n_rst2      = 1'b1;
        m2.imem_ack = 1'b1;
        m2.opcode   = 7'b1111111;
        tick();
        m2.imem_ack = 1'b0;
        chk("illegal_nop_retire", {27'd0, m2.retire, m2.pc_we, m2.pc_src, m2.fault}, 32'b11000);
        tick();
        chk("illegal_nop_refetch", {30'd0, m2.imem_req, m2.fault}, 32'b10);
        tick();
        tick();
        tick();
        m2.imem_ack = 1'b1;
        m2.opcode   = 7'b0010011;
        #1;
        chk("ack_at_limit_wins", {30'd0, m2.ir_we, m2.fault}, 32'b10);
        tick();
        m2.imem_ack = 1'b0;
        chk("ack_at_limit_no_fault", 32'(m2.fault), 32'd0);

        n_rst2 = 1'b0;
        tick();
        n_rst2 = 1'b1;
        n = 0;
        while (!m2.fault && n < 40) begin
            tick();
            n++;
        end
        chk("fetch_timeout_cycles_t4", 32'(n), 32'd4);

        tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max wait cycles for a memory ack before fault.
REQ-002 Parameter ILLEGAL_TRAP, default 1: 1 = unknown opcode enters TRAP; 0 = unknown opcode retires as NOP.
REQ-003 clk  in  1  single system clock, rising edge.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  7  instr[6:0] from instruction register.
REQ-006 branch_taken  in  1  branch compare result from ALU, sampled in EXEC.
REQ-007 imem_ack  in  1  instruction memory data valid.
REQ-008 dmem_ack  in  1  data memory access complete.
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 dmem_req  out  1  data access request; mem_wr selects write.
REQ-011 ir_we  out  1  instruction register load strobe.
REQ-012 pc_we  out  1  PC update strobe.
REQ-013 reg_we  out  1  register file write strobe.
REQ-014 alu_src  out  1  0: rs2, 1: immediate.
REQ-015 alu_op  out  2  00 add, 01 branch, 10 R-type, 11 I-type.
REQ-016 pc_src  out  2  00 PC+4, 01 PC+imm, 10 rs1+imm.
REQ-017 mem_wr  out  1  store when dmem_req=1.
REQ-018 mem_to_reg  out  1  writeback from memory data.
REQ-019 uncond_jump / auipc / utype  out  1 each  rd=PC+4; ALU A=PC; U-type immediate.
REQ-020 retire  out  1  one-cycle pulse per completed instruction.
REQ-021 fault  out  1  sticky; high in TRAP.

Function
REQ-022 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; reset state FETCH.
REQ-023 FETCH: imem_req=1 until imem_ack; on ack, ir_we=1 that cycle -> DECODE.
REQ-024 DECODE: one cycle; opcode class latched into a register; later opcode changes ignored until next DECODE.
REQ-025 Unknown opcode in DECODE: ILLEGAL_TRAP=1 -> TRAP; else pc_we=1, pc_src=00, retire=1 -> FETCH.
REQ-026 Per-class datapath controls, held EXEC through WB: BTYPE alu_src=0 alu_op=01; RTYPE alu_src=0 alu_op=10; ITYPE alu_op=11; LOAD/STORE alu_op=00; JAL pc_src=01 uncond_jump=1; JALR pc_src=10 uncond_jump=1; LUI utype=1; AUIPC auipc=1 utype=1; all else default alu_src=1, alu_op=00, pc_src=00, flags 0.
REQ-027 EXEC BTYPE: pc_we=1, pc_src=01 if branch_taken else 00, retire=1 -> FETCH.
REQ-028 EXEC JAL/JALR: reg_we=1, pc_we=1, retire=1 -> FETCH.
REQ-029 EXEC LOAD/STORE -> MEM; RTYPE/ITYPE/LUI/AUIPC -> WB.
REQ-030 MEM: dmem_req=1 (mem_wr=1 for STORE) held until dmem_ack; STORE ack: pc_we=1, retire=1 -> FETCH; LOAD ack -> WB.
REQ-031 WB: reg_we=1, mem_to_reg=1 for LOAD, pc_we=1, pc_src=00, retire=1 -> FETCH.
REQ-032 Wait counter (width clog2(MEM_TIMEOUT+1)) clears on entry to FETCH/MEM, increments per un-acked cycle; reaching MEM_TIMEOUT without ack -> TRAP.
REQ-033 Ack in the same cycle the counter hits MEM_TIMEOUT SHALL win (no fault).
REQ-034 Acks outside FETCH/MEM SHALL be ignored.
REQ-035 TRAP: all strobes 0, fault=1, remain until reset.
REQ-036 ir_we, pc_we, reg_we, mem_wr, dmem_req, imem_req, retire SHALL be 0 in every state not listed above.

Reset
REQ-037 n_rst low SHALL immediately force state FETCH, counter 0, latched class NOP, fault 0, all strobes 0, controls to defaults.
REQ-038 Reset mid-access SHALL drop dmem_req/mem_wr asynchronously; first cycle after release issues imem_req=1.

Structure
REQ-039 Opcode constants, state enum, alu_op/pc_src encodings SHALL live in shared package rv_ctrl_pkg.
REQ-040 Opcode-to-class/control decode SHALL be sub-module ctrl_decode (combinational); FSM and counter in multicycle_control.

Verification
REQ-041 ITYPE 0010011, imem_ack in first FETCH cycle -> reg_we=1, pc_we=1, retire=1 in 4th cycle after reset release.
REQ-042 BTYPE 1100011, branch_taken=1 -> EXEC pc_we=1, pc_src=01, reg_we=0, next state FETCH.
REQ-043 LOAD, dmem_ack 3 cycles late -> dmem_req high 4 cycles, then WB reg_we=1, mem_to_reg=1.
REQ-044 imem_ack never, MEM_TIMEOUT=15 -> fault=1 after 15 un-acked cycles, stays 1; later acks ignored.
REQ-045 Opcode 1111111: ILLEGAL_TRAP=1 -> TRAP after DECODE; ILLEGAL_TRAP=0 -> retire=1, pc_src=00.
REQ-046 n_rst low during STORE MEM -> dmem_req=0, mem_wr=0 same cycle; imem_req=1 first cycle after release.
